// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: circular {pc, inst} buffer between IFU and IDU with
// first-word fall-through head, valid/ready on both sides and a redirect flush.
module inst_fetch_queue #(
  parameter  int CPU_WIDTH = 32,
  parameter  int DEPTH     = 4,
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CPU_WIDTH-1:0] in_pc,
  input  logic [CPU_WIDTH-1:0] in_inst,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CPU_WIDTH-1:0] out_pc,
  output logic [CPU_WIDTH-1:0] out_inst,
  output logic [PTR_W:0]       count
);

  logic [PTR_W:0]                    wr_ptr, rd_ptr;
  logic                              empty, full, push, pop;
  logic [DEPTH-1:0]                  we;
  logic [DEPTH-1:0][CPU_WIDTH-1:0]   ent_pc, ent_inst;

  // Extra MSB on each pointer tells full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) &&
                 (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
  assign count = wr_ptr - rd_ptr;

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage carries no reset; stale contents are hidden by the empty mask.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign we[i] = push & (wr_ptr[PTR_W-1:0] == PTR_W'(i));
    always_ff @(posedge clk) begin
      if (we[i]) begin
        ent_pc[i]   <= in_pc;
        ent_inst[i] <= in_inst;
      end
    end
  end

  assign out_pc   = empty ? '0 : ent_pc[rd_ptr[PTR_W-1:0]];
  assign out_inst = empty ? '0 : ent_inst[rd_ptr[PTR_W-1:0]];

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Instruction buffer between the IFU (fetch) and the IDU (decode).
- Decouples fetch from decode stalls using a valid/ready handshake on both sides.
- Each entry holds a {pc, inst} pair.
- A synchronous flush discards all buffered instructions when a JAL/JALR or branch redirect is taken.

Parameters:
- CPU_WIDTH, 32, width of the pc and instruction fields (matches the `CPU_WIDTH define).
- DEPTH, 4, number of entries; must be a power of two, 2..16.
- PTR_W, $clog2(DEPTH), pointer width; derived, must not be overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rstn  input  1  reset, asynchronous and active-high: asserted = 1 despite the name.
- flush  input  1  synchronous queue clear (redirect from EXU).
- in_valid  input  1  IFU presents a fetched instruction.
- in_ready  output  1  queue can accept this cycle.
- in_pc  input  CPU_WIDTH  pc of the incoming instruction.
- in_inst  input  CPU_WIDTH  incoming instruction word.
- out_valid  output  1  head entry is valid for the IDU.
- out_ready  input  1  IDU consumes the head this cycle.
- out_pc  output  CPU_WIDTH  pc of the head entry.
- out_inst  output  CPU_WIDTH  instruction of the head entry.
- count  output  PTR_W+1  number of occupied entries, 0..DEPTH.

Behaviour:
- Storage and pointers
  - Circular buffer; wr_ptr and rd_ptr are each PTR_W+1 bits, with the extra MSB used as a wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = (PTR_W LSBs equal) and (MSBs differ).
  - count = wr_ptr - rd_ptr, modulo 2^(PTR_W+1).
- Push / pop
  - push = in_valid & in_ready & ~flush.
  - pop = out_valid & out_ready & ~flush.
- in_ready = ~full. There is no pass-through on a full queue: a pop in the same cycle does not raise in_ready.
- Head outputs are first-word fall-through:
  - out_valid = ~empty.
  - out_pc and out_inst are read combinationally from entry rd_ptr[PTR_W-1:0].
  - When empty, out_pc and out_inst are 0; storage is not reset and must be masked to 0 while empty.
- Latency: an entry pushed at edge N is visible on out_* after edge N (one cycle). There is no same-cycle bypass from in_* to out_*.
- Simultaneous push and pop
  - Both pointers advance and count is unchanged.
  - Legal whenever the queue is non-empty and not full.
  - When empty only push happens, because out_valid = 0.
- Wrap-around: pointers increment modulo 2^(PTR_W+1). Data order is preserved across the wrap.
- Flush
  - At the next edge, wr_ptr = rd_ptr = 0 and count = 0.
  - A push or pop presented in the flush cycle is discarded.
  - in_ready is still driven as ~full during the flush cycle, but the accepted word is dropped.
  - The IFU re-issues from the redirect target.
- Reset (rstn = 1, asynchronous)
  - wr_ptr = rd_ptr = 0, so count = 0, out_valid = 0, in_ready = 1, out_pc = out_inst = 0.
  - Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.
  - Outputs hold their reset values until the first edge after rstn falls.
- Handshake stability (required of the bench, checked by assertion)
  - Once in_valid is high with in_ready low, in_pc and in_inst must stay stable until accepted.
  - out_* must stay stable while out_valid & ~out_ready.
- No internal FSM beyond the pointers. The ebreak check stays in the CPU top and consumes out_inst.

Test Plan:
1. Reset then idle: assert rstn for 2 cycles, release.
   - Required: out_valid=0, in_ready=1, count=0, out_inst=0.
2. Single instruction latency: push pc=0x80000000, inst=0x00000413 at edge N with out_ready=0.
   - Required: after edge N, out_valid=1, out_pc=0x80000000, out_inst=0x00000413, count=1.
   - Pop at N+1; required: count=0, out_valid=0.
3. Fill to full: push 4 entries (pc 0x80000000..0x8000000C) with out_ready=0.
   - Required: count=4, in_ready=0.
   - A 5th in_valid is not accepted and count stays 4.
   - Pop all 4; required: they come out in order 0x80000000..0x8000000C.
4. Wrap with simultaneous push and pop: hold 2 entries, then do 10 cycles of push+pop.
   - Required: count stays 2, pointers wrap past DEPTH, and output order matches input order exactly.
5. Flush with pending push: 3 entries buffered, assert flush with in_valid=1 and out_ready=1.
   - Required: next cycle count=0 and out_valid=0; the flushed-cycle word never appears on out_*.
6. Async reset mid-stream: with 3 entries buffered, raise rstn between clock edges.
   - Required: out_valid drops to 0 and count=0 before the next edge; normal push works after release.
